fp_normalize_arbiter: RTL

//  Shares one fpNormalize instance (fixed-latency, ce-gated pipeline) between NREQ upstream
//  FP units (add/mul/div/...). Picks one request per cycle in round-robin order and drives
//  the normalizer inputs. Tracks a requester-ID tag alongside each in-flight operation,

---
 rtl/fp_normalize_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fp_normalize_arbiter.sv
// Round-robin front end that time-shares one fixed-latency, ce-gated normalizer among NREQ
// requesters, carrying a requester tag through the pipe so each result returns to its issuer.
module fp_normalize_arbiter #(
  parameter  int NREQ = 4,
  parameter  int IW   = 32,
  parameter  int OW   = 27,
  parameter  int LAT  = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(LAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_under,
  output logic                 norm_ce,
  output logic [IW-1:0]        norm_i,
  output logic                 norm_under_i,
  input  logic [OW-1:0]        norm_o,
  input  logic                 norm_under_o,
  input  logic                 norm_inex_o,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [OW-1:0]        res_o,
  output logic                 res_under,
  output logic                 res_inexact,
  input  logic [NREQ-1:0]      res_ready,
  output logic                 busy,
  output logic [CW-1:0]        inflight
);

  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          gnt_id;
  logic                    any_req;
  logic                    issue;
  logic                    stall;
  logic                    xfer;
  logic [IW-1:0]           sel_data;
  logic                    sel_under;
  logic [IW-1:0]           hold_data;
  logic                    hold_under;
  logic [LAT-1:0]          vld_p;
  logic [LAT-1:0][IDW-1:0] id_p;

  // Rotating priority search starting at rr_ptr; the first requester found wins.
  always_comb begin
    int          idx;
    logic [IDW-1:0] cand;
    any_req = 1'b0;
    gnt_id  = rr_ptr;
    idx     = 0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_under = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_data  = req_data[k*IW +: IW];
        sel_under = req_under[k];
      end
    end
  end

  assign res_valid   = vld_p[LAT-1];
  assign res_id      = id_p[LAT-1];
  assign res_o       = norm_o;
  assign res_under   = norm_under_o;
  assign res_inexact = norm_inex_o;

  assign stall   = res_valid & ~res_ready[res_id];
  assign xfer    = res_valid &  res_ready[res_id];
  assign norm_ce = ~stall;
  // No grants while reset is asserted, even though the pipe keeps flushing.
  assign issue   = rst_n & any_req & norm_ce;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  // Idle cycles replay the last operand so the normalizer inputs do not toggle.
  assign norm_i       = issue ? sel_data  : hold_data;
  assign norm_under_i = issue ? sel_under : hold_under;

  always_ff @(posedge clk) begin
    if (issue) begin
      hold_data  <= sel_data;
      hold_under <= sel_under;
    end
  end

  // Tag pipe stage boundary: advances in lockstep with the normalizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (norm_ce) begin
      vld_p <= {vld_p[LAT-2:0], issue};
    end
  end

  always_ff @(posedge clk) begin
    if (norm_ce) id_p <= {id_p[LAT-2:0], gnt_id};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Occupancy follows issues and transfers, not ce, so a same-cycle pair cancels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({issue, xfer})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = |inflight;

endmodule
